pll_reset_sequencer: RTL

Reset and lock supervisor for the clock generator PLL, clocked from the 50 MHz board reference.
- Drives the PLL reset and issues a timed PLL reset pulse after system reset.
- Waits for a stable, debounced lock, retrying on timeout, and releases the downstream system reset only once lock is stable.
- Re-sequences automatically on loss of lock.
- Reports health status to the control/status logic.

---
 rtl/pll_seq_pkg.sv | 35 +++
 rtl/pll_reset_sequencer_if.sv | 26 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/pll_reset_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared encodings and helpers for the PLL reset/lock sequencer.
package pll_seq_pkg;

  localparam int STATE_W = 3;
  localparam int LOSS_W  = 8;

  localparam logic [STATE_W-1:0] S_PLL_RST   = 3'd0;
  localparam logic [STATE_W-1:0] S_WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] S_STABLE    = 3'd2;
  localparam logic [STATE_W-1:0] S_RUN       = 3'd3;
  localparam logic [STATE_W-1:0] S_FAIL      = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST   = S_PLL_RST,
    ST_WAIT_LOCK = S_WAIT_LOCK,
    ST_STABLE    = S_STABLE,
    ST_RUN       = S_RUN,
    ST_FAIL      = S_FAIL
  } seq_state_e;

  function automatic int max_cycles(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Event counter that sticks at all-ones instead of wrapping.
  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL sequencer and its surroundings.
interface pll_reset_sequencer_if #(
  parameter int MAX_RETRIES = 3
);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  logic                             pll_locked;
  logic                             clr_fail;
  logic                             pll_rst;
  logic                             sys_rst_n;
  logic                             fail;
  logic [pll_seq_pkg::STATE_W-1:0]  state;
  logic [RW-1:0]                    retry_cnt;
  logic [pll_seq_pkg::LOSS_W-1:0]   loss_cnt;

  modport master (
    output pll_locked, clr_fail,
    input  pll_rst, sys_rst_n, fail, state, retry_cnt, loss_cnt
  );

  modport slave (
    input  pll_locked, clr_fail,
    output pll_rst, sys_rst_n, fail, state, retry_cnt, loss_cnt
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous status inputs, synchronous active-low reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset and lock supervisor: timed PLL reset pulse, qualified lock with retry,
// downstream reset release and automatic re-sequencing on loss of lock.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOSS_FILTER_CYCLES  = 4,
  parameter int MAX_RETRIES         = 3
) (
  input logic                  refclk,
  input logic                  rst,
  pll_reset_sequencer_if.slave bus
);

  // state     | meaning
  // PLL_RST   | PLL held in reset for PLL_RST_CYCLES
  // WAIT_LOCK | waiting for synchronised lock; timeout retries or fails
  // STABLE    | lock must hold for LOCK_STABLE_CYCLES in a row
  // RUN       | downstream released; filtered loss of lock re-sequences
  // FAIL      | retries exhausted, PLL held in reset until clr_fail

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int CW = $clog2(max_cycles(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                        LOCK_STABLE_CYCLES, LOSS_FILTER_CYCLES)) + 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LOSS_LAST = CW'(LOSS_FILTER_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  logic [STATE_W-1:0] r_state;
  logic [CW-1:0]      r_cnt;
  logic [RW-1:0]      r_retry;
  logic [LOSS_W-1:0]  r_loss;
  logic               r_pll_rst;
  logic               r_sys_rst_n;
  logic               r_fail;

  logic               w_locked_s;
  logic [STATE_W-1:0] w_state_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [RW-1:0]      w_retry_nxt;
  logic [LOSS_W-1:0]  w_loss_nxt;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk   (refclk),
    .i_rst_n (rst),
    .i_d     (bus.pll_locked),
    .o_q     (w_locked_s)
  );

  // r_cnt is the phase timer in PLL_RST/WAIT_LOCK/STABLE and the dropout filter in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_loss_nxt  = r_loss;
    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nxt = S_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TMO_LAST) begin
          w_cnt_nxt = '0;
          if (r_retry < RETRY_MAX) begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = S_PLL_RST;
          end else begin
            w_state_nxt = S_FAIL;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STABLE: begin
        if (!w_locked_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STB_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (w_locked_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LOSS_LAST) begin
          w_state_nxt = S_PLL_RST;
          w_cnt_nxt   = '0;
          w_loss_nxt  = sat_inc(r_loss);
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_FAIL: begin
        if (bus.clr_fail) begin
          w_state_nxt = S_PLL_RST;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_PLL_RST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      r_state     <= S_PLL_RST;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_loss      <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_loss      <= w_loss_nxt;
      r_pll_rst   <= (w_state_nxt == S_PLL_RST) || (w_state_nxt == S_FAIL);
      r_sys_rst_n <= (w_state_nxt == S_RUN);
      r_fail      <= (w_state_nxt == S_FAIL);
    end
  end

  assign bus.state     = r_state;
  assign bus.retry_cnt = r_retry;
  assign bus.loss_cnt  = r_loss;
  assign bus.pll_rst   = r_pll_rst;
  assign bus.sys_rst_n = r_sys_rst_n;
  assign bus.fail      = r_fail;

endmodule
